// File: rtl/sha2_pkg.sv
// Shared SHA-2 (256/224) constants, state encoding and round helper functions.
package sha2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV_256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV_224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables a..h packed as {a,b,c,d,e,f,g,h}.
module sha256_round
  import sha2_pkg::*;
(
  input  logic [255:0] state_in,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] state_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_in;

  assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
  assign t2 = big_sigma0(a) + maj(a, b, c);

  assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256/SHA-224 compression engine, UNROLL rounds per clock, with
// internal multi-block chaining and a held valid/ready digest output.
module sha256_compress
  import sha2_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] chunk,
  input  logic         first,
  input  logic         last,
  input  logic         sha224,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $fatal(1, "sha256_compress: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [6:0] STEP     = 7'(UNROLL);
  localparam logic [6:0] LAST_CNT = 7'(64 - UNROLL);

  state_t        state, state_next;
  logic [511:0]  w_win;
  logic [255:0]  work;
  logic [255:0]  h_reg;
  logic [255:0]  h_sum;
  logic [6:0]    round_cnt;
  logic          last_q;
  logic          mode_224;
  logic          accept;
  logic [511:0]  win_final;
  logic [255:0]  work_final;

  assign accept = in_valid && (state == IDLE);

  // Window word p sits at [511-32p -: 32]; word 0 is W[t] for the current round.
  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    logic [511:0] win_in, win_out;
    logic [255:0] st_in, st_out;
    logic [5:0]   t;
    logic [31:0]  w_new;

    if (i == 0) begin : g_head
      assign win_in = w_win;
      assign st_in  = work;
    end else begin : g_link
      assign win_in = g_round[i-1].win_out;
      assign st_in  = g_round[i-1].st_out;
    end

    assign t       = round_cnt[5:0] + 6'(i);
    assign w_new   = small_sigma1(win_in[63:32]) + win_in[223:192]
                   + small_sigma0(win_in[479:448]) + win_in[511:480];
    assign win_out = {win_in[479:0], w_new};

    sha256_round u_round (
      .state_in  (st_in),
      .k         (K[t]),
      .w         (win_in[511:480]),
      .state_out (st_out)
    );
  end

  assign win_final  = g_round[UNROLL-1].win_out;
  assign work_final = g_round[UNROLL-1].st_out;

  // NOTE: every variable assigned in always_comb gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    h_sum = '0;
    for (int j = 0; j < 8; j++) begin
      h_sum[32*j +: 32] = h_reg[32*j +: 32] + work[32*j +: 32];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = ROUND;
      ROUND:   if (round_cnt == LAST_CNT) state_next = ADD;
      ADD:     state_next = last_q ? DONE : IDLE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_win     <= '0;
      work      <= '0;
      h_reg     <= IV_256;
      round_cnt <= '0;
      last_q    <= 1'b0;
      mode_224  <= 1'b0;
      digest    <= '0;
    end else begin
      if (accept) begin
        w_win     <= chunk;
        last_q    <= last;
        round_cnt <= '0;
        if (first) begin
          h_reg    <= sha224 ? IV_224 : IV_256;
          work     <= sha224 ? IV_224 : IV_256;
          mode_224 <= sha224;
        end else begin
          work <= h_reg;
        end
      end else if (state == ROUND) begin
        w_win     <= win_final;
        work      <= work_final;
        round_cnt <= round_cnt + STEP;
      end else if (state == ADD) begin
        h_reg <= h_sum;
        if (last_q) begin
          digest <= mode_224 ? {h_sum[255:32], 32'h0} : h_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Directed-vector bench for sha256_compress: known digests, latency, chaining,
// output hold, reset abort, and all legal UNROLL settings.
module tb_sha256_compress;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] TWO_BLK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2  = {{15{32'h0}}, 32'h000001c0};

  localparam logic [255:0] D_ABC    = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_ABC224 = {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0};
  localparam logic [255:0] D_TWO    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_EMPTY  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [511:0] chunk = '0;
  logic         first = 1'b0;
  logic         last = 1'b0;
  logic         sha224 = 1'b0;
  logic         out_ready = 1'b0;

  logic         in_ready_u  [4];
  logic         out_valid_u [4];
  logic         busy_u      [4];
  logic [255:0] digest_u    [4];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sha256_compress #(.UNROLL(1)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_u[0]),
    .chunk(chunk), .first(first), .last(last), .sha224(sha224),
    .out_valid(out_valid_u[0]), .out_ready(out_ready), .digest(digest_u[0]), .busy(busy_u[0])
  );

  sha256_compress #(.UNROLL(2)) dut_u2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_u[1]),
    .chunk(chunk), .first(first), .last(last), .sha224(sha224),
    .out_valid(out_valid_u[1]), .out_ready(out_ready), .digest(digest_u[1]), .busy(busy_u[1])
  );

  sha256_compress #(.UNROLL(4)) dut_u4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_u[2]),
    .chunk(chunk), .first(first), .last(last), .sha224(sha224),
    .out_valid(out_valid_u[2]), .out_ready(out_ready), .digest(digest_u[2]), .busy(busy_u[2])
  );

  sha256_compress #(.UNROLL(8)) dut_u8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_u[3]),
    .chunk(chunk), .first(first), .last(last), .sha224(sha224),
    .out_valid(out_valid_u[3]), .out_ready(out_ready), .digest(digest_u[3]), .busy(busy_u[3])
  );

  // Presents one block to the main engine; returns at the falling edge after the accept edge.
  task automatic send_block(input logic [511:0] c, input logic f, input logic l, input logic s);
    int n;
    @(negedge clock);
    n = 0;
    while (!in_ready_u[0] && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (in_ready_u[0] !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%0b after %0d cycles, required 1", in_ready_u[0], n);
    end
    chunk = c; first = f; last = l; sha224 = s; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; first = 1'b0; last = 1'b0; sha224 = 1'b0;
  endtask

  // Counts falling edges until the main engine raises out_valid (bounded at 200).
  task automatic wait_out(output int lat);
    int n;
    n = 0;
    while (!out_valid_u[0] && n < 200) begin
      @(negedge clock);
      n++;
    end
    lat = n;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({in_ready_u[0], out_valid_u[0], busy_u[0]} !== 3'b100 || digest_u[0] !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy/vld/busy=%b digest=%h, required 100 and 0",
               {in_ready_u[0], out_valid_u[0], busy_u[0]}, digest_u[0]);
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({in_ready_u[0], out_valid_u[0], busy_u[0]} !== 3'b100) begin
      errors++;
      $display("FAIL post_reset_idle: rdy/vld/busy=%b, required 100", {in_ready_u[0], out_valid_u[0], busy_u[0]});
    end
  endtask

  task automatic test_abc();
    int lat;
    send_block(ABC_BLK, 1'b1, 1'b1, 1'b0);
    checks++;
    if (busy_u[0] !== 1'b1) begin
      errors++;
      $display("FAIL abc_busy: busy=%0b, required 1", busy_u[0]);
    end
    wait_out(lat);
    checks++;
    if (lat != 65) begin
      errors++;
      $display("FAIL abc_latency: %0d cycles, required 65", lat);
    end
    checks++;
    if (digest_u[0] !== D_ABC) begin
      errors++;
      $display("FAIL abc_digest: got %h, required %h", digest_u[0], D_ABC);
    end
    release_out();
    checks++;
    if (out_valid_u[0] !== 1'b0 || in_ready_u[0] !== 1'b1) begin
      errors++;
      $display("FAIL abc_release: out_valid=%0b in_ready=%0b, required 0 and 1", out_valid_u[0], in_ready_u[0]);
    end
  endtask

  task automatic test_sha224();
    int lat;
    out_ready = 1'b1;
    send_block(ABC_BLK, 1'b1, 1'b1, 1'b1);
    wait_out(lat);
    checks++;
    if (lat != 65) begin
      errors++;
      $display("FAIL sha224_latency: %0d cycles, required 65", lat);
    end
    checks++;
    if (digest_u[0] !== D_ABC224) begin
      errors++;
      $display("FAIL sha224_digest: got %h, required %h", digest_u[0], D_ABC224);
    end
    @(negedge clock);
    checks++;
    if (out_valid_u[0] !== 1'b0 || in_ready_u[0] !== 1'b1) begin
      errors++;
      $display("FAIL sha224_one_cycle_valid: out_valid=%0b in_ready=%0b, required 0 and 1",
               out_valid_u[0], in_ready_u[0]);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_two_block();
    int  n;
    int  lat;
    bit  early_valid;
    send_block(TWO_BLK1, 1'b1, 1'b0, 1'b0);
    n = 0;
    early_valid = 1'b0;
    while (!in_ready_u[0] && n < 200) begin
      @(negedge clock);
      n++;
      if (out_valid_u[0]) early_valid = 1'b1;
    end
    checks++;
    if (n != 65) begin
      errors++;
      $display("FAIL two_block_ready_return: %0d cycles, required 65", n);
    end
    checks++;
    if (early_valid) begin
      errors++;
      $display("FAIL two_block_no_mid_valid: out_valid seen=1, required 0");
    end
    // sha224 is set on the chained block and must be ignored.
    send_block(TWO_BLK2, 1'b0, 1'b1, 1'b1);
    wait_out(lat);
    checks++;
    if (lat != 65 || digest_u[0] !== D_TWO) begin
      errors++;
      $display("FAIL two_block_digest: latency %0d digest %h, required 65 and %h", lat, digest_u[0], D_TWO);
    end
    release_out();
  endtask

  task automatic test_unroll();
    int lat [4];
    int exp_lat;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) lat[i] = -1;
    send_block(EMPTY_BLK, 1'b1, 1'b1, 1'b0);
    for (int n = 1; n <= 80; n++) begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        if (out_valid_u[i] && lat[i] < 0) lat[i] = n;
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp_lat = 64 / (1 << i) + 1;
      checks++;
      if (lat[i] != exp_lat) begin
        errors++;
        $display("FAIL unroll%0d_latency: %0d cycles, required %0d", 1 << i, lat[i], exp_lat);
      end
      checks++;
      if (digest_u[i] !== D_EMPTY) begin
        errors++;
        $display("FAIL unroll%0d_digest: got %h, required %h", 1 << i, digest_u[i], D_EMPTY);
      end
    end
    release_out();
  endtask

  task automatic test_hold();
    int  lat;
    bit  bad;
    send_block(ABC_BLK, 1'b1, 1'b1, 1'b0);
    wait_out(lat);
    bad = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (n == 3) begin
        chunk = EMPTY_BLK; first = 1'b1; last = 1'b1; in_valid = 1'b1;
      end
      if (n == 8) begin
        in_valid = 1'b0; first = 1'b0; last = 1'b0;
      end
      @(negedge clock);
      if (out_valid_u[0] !== 1'b1 || in_ready_u[0] !== 1'b0 || digest_u[0] !== D_ABC) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_stable: out_valid=%0b in_ready=%0b digest=%h, required 1, 0, %h",
               out_valid_u[0], in_ready_u[0], digest_u[0], D_ABC);
    end
    release_out();
    repeat (3) @(negedge clock);
    checks++;
    if (out_valid_u[0] !== 1'b0 || busy_u[0] !== 1'b0 || in_ready_u[0] !== 1'b1 || digest_u[0] !== D_ABC) begin
      errors++;
      $display("FAIL hold_release_idle: out_valid=%0b busy=%0b in_ready=%0b digest=%h, required 0, 0, 1, %h",
               out_valid_u[0], busy_u[0], in_ready_u[0], digest_u[0], D_ABC);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    send_block(ABC_BLK, 1'b1, 1'b1, 1'b1);
    repeat (29) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready_u[0], out_valid_u[0], busy_u[0]} !== 3'b100 || digest_u[0] !== '0) begin
      errors++;
      $display("FAIL abort_reset_state: rdy/vld/busy=%b digest=%h, required 100 and 0",
               {in_ready_u[0], out_valid_u[0], busy_u[0]}, digest_u[0]);
    end
    @(negedge clock);
    reset_n = 1'b1;
    // A non-first block right after reset chains from the SHA-256 IV.
    send_block(ABC_BLK, 1'b0, 1'b1, 1'b1);
    wait_out(lat);
    checks++;
    if (lat != 65 || digest_u[0] !== D_ABC) begin
      errors++;
      $display("FAIL abort_then_abc: latency %0d digest %h, required 65 and %h", lat, digest_u[0], D_ABC);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_sha224();
    test_two_block();
    test_unroll();
    test_hold();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
